// File: rtl/fold_psum_accumulator_pkg.sv
// Shared types and default sizes for the fold partial-sum accumulator.
// Holds the FSM state encoding, default widths, depth and PAR_CH.
package fold_psum_accumulator_pkg;

  localparam int IN_W_D    = 16;
  localparam int ACC_W_D   = 32;
  localparam int MAX_PIX_D = 196;
  localparam int PIX_W_D   = 16;

  // channels pre-reduced into one beat; shared with fold_controller
  localparam int PAR_CH    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fold_psum_accumulator_if.sv
// Fold-control and psum stream bundle of the accumulator.
// master: fold controller / stream source+sink side; slave: accumulator.
interface fold_psum_accumulator_if
  import fold_psum_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int PIX_W = PIX_W_D
) ();

  logic                    fold_start;
  logic                    first_fold;
  logic                    last_fold;
  logic [PIX_W-1:0]        npix;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    compute_done;
  logic                    busy;

  modport master (
    output fold_start, first_fold, last_fold, npix,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  compute_done, busy
  );

  modport slave (
    input  fold_start, first_fold, last_fold, npix,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output compute_done, busy
  );

endinterface

// File: rtl/fold_psum_accumulator_psum_buffer.sv
// psum_buffer: DEPTH x W register array, not reset.
// Ports: clk, one sync write (i_we/i_waddr/i_wdata), two async reads (a, b).
module psum_buffer #(
  parameter int DEPTH = 196,
  parameter int W     = 32,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (int'(i_waddr) < DEPTH))
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = (int'(i_raddr_a) < DEPTH) ?
                     r_mem[i_raddr_a] : '0;
  assign o_rdata_b = (int'(i_raddr_b) < DEPTH) ?
                     r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/fold_psum_accumulator.sv
// Accumulates per-pixel psums over channel folds; drains on last fold.
// Ports: clk, rst (async, high), io (slave). Option: PSUM_RELU_EN.
module fold_psum_accumulator
  import fold_psum_accumulator_pkg::*;
#(
  parameter int IN_W    = IN_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int MAX_PIX = MAX_PIX_D,
  parameter int PIX_W   = PIX_W_D
) (
  input logic                   clk,
  input logic                   rst,
  fold_psum_accumulator_if.slave io
);

  localparam int AW = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_first;
  logic             r_last;
  logic [PIX_W-1:0] r_n;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [PIX_W-1:0] r_out_cnt;
  logic [PIX_W-1:0] w_n_clamp;

  logic w_start;
  logic w_acc;
  logic w_hs;
  logic w_pix_last;
  logic w_out_last;

  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_rd_pix;
  logic signed [ACC_W-1:0] w_rd_out;
  logic signed [ACC_W-1:0] w_wdata;
  logic signed [ACC_W-1:0] w_drain;

  assign w_n_clamp = (io.npix > PIX_W'(MAX_PIX)) ?
                     PIX_W'(MAX_PIX) : io.npix;

  assign w_start = (r_state == S_IDLE) && io.fold_start;
  assign w_acc   = (r_state == S_ACCUM) && io.in_valid;
  assign w_hs    = (r_state == S_DRAIN) && io.out_ready;

  assign w_pix_last = (r_pix_cnt == r_n - PIX_W'(1));
  assign w_out_last = (r_out_cnt == r_n - PIX_W'(1));

  assign w_sext = {{(ACC_W-IN_W){io.in_data[IN_W-1]}},
                   io.in_data};

  // first fold overwrites stale contents; later folds add (wrapping)
  assign w_wdata = r_first ? w_sext : w_rd_pix + w_sext;

  psum_buffer #(
    .DEPTH (MAX_PIX),
    .W     (ACC_W),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_acc),
    .i_waddr   (r_pix_cnt[AW-1:0]),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_pix_cnt[AW-1:0]),
    .i_raddr_b (r_out_cnt[AW-1:0]),
    .o_rdata_a (w_rd_pix),
    .o_rdata_b (w_rd_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (io.fold_start)
          w_state_nxt = (w_n_clamp == '0) ?
                        S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (io.in_valid && w_pix_last)
          w_state_nxt = r_last ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (io.out_ready && w_out_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_n       <= '0;
      r_pix_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_first   <= io.first_fold;
        r_last    <= io.last_fold;
        r_n       <= w_n_clamp;
        r_pix_cnt <= '0;
        r_out_cnt <= '0;
      end
      if (w_acc)
        r_pix_cnt <= r_pix_cnt + PIX_W'(1);
      if (w_hs)
        r_out_cnt <= r_out_cnt + PIX_W'(1);
    end
  end

`ifdef PSUM_RELU_EN
  // clamp negatives on the way out only; buffer keeps raw sums
  assign w_drain = w_rd_out[ACC_W-1] ? '0 : w_rd_out;
`else
  assign w_drain = w_rd_out;
`endif

  assign io.in_ready     = (r_state == S_ACCUM);
  assign io.out_valid    = (r_state == S_DRAIN);
  assign io.out_data     = (r_state == S_DRAIN) ? w_drain : '0;
  assign io.compute_done = (r_state == S_DONE);
  assign io.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fold_psum_accumulator.sv
// Self-checking bench for fold_psum_accumulator.
// Table-driven folds plus hand-written stall/abort/boundary sequences.
module tb_fold_psum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fold_psum_accumulator_if ifc ();

  fold_psum_accumulator dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_evt = 0;
  int acc_cnt  = 0;
  int hs_cnt   = 0;
  int rdy_cnt  = 0;
  int ov_cnt   = 0;

  int exp_q[$];
  int drv_q[$];

  bit stall_mode = 0;
  int stall_k    = 0;
  bit held_v     = 0;
  int held_d     = 0;

  task automatic check(input string nm,
                       input longint act,
                       input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  function automatic int exp_out(input int x);
`ifdef PSUM_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      ifc.out_ready = (stall_k % 4 == 0) ||
                      (stall_k % 4 == 3);
      stall_k++;
    end else begin
      ifc.out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (held_v && ifc.out_valid)
        check("stall_hold",
              longint'(ifc.out_data), held_d);
      held_v = ifc.out_valid && !ifc.out_ready;
      held_d = ifc.out_data;
      if (ifc.out_valid && ifc.out_ready) begin
        hs_cnt++;
        last_evt = cyc;
        if (exp_q.size() == 0)
          check("unexpected_out", 1, 0);
        else
          check("out_data",
                longint'(ifc.out_data),
                exp_q.pop_front());
      end
      if (ifc.in_valid && ifc.in_ready) begin
        acc_cnt++;
        last_evt = cyc;
      end
      if (ifc.in_ready) rdy_cnt++;
      if (ifc.out_valid) ov_cnt++;
      if (ifc.compute_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_fold(input bit f,
                            input bit l,
                            input int np);
    @(posedge clk); #1;
    ifc.fold_start = 1'b1;
    ifc.first_fold = f;
    ifc.last_fold  = l;
    ifc.npix       = 16'(np);
    @(posedge clk); #1;
    ifc.fold_start = 1'b0;
    ifc.first_fold = 1'b0;
    ifc.last_fold  = 1'b0;
    ifc.npix       = '0;
    if (np > 0)
      check("in_ready_latency", ifc.in_ready, 1);
  endtask

  task automatic send_beats();
    while (drv_q.size() > 0) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'(drv_q.pop_front());
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
  endtask

  task automatic wait_done(input string nm,
                           input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      check({nm, "_done_lat"}, done_cyc - last_evt, 1);
      repeat (2) @(posedge clk);
      check({nm, "_done_once"}, done_cnt - d0, 1);
    end
    #1;
  endtask

  typedef struct {
    bit first;
    bit last;
    int npix;
    int d[4];
    int e[4];
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0;
    int fs;
    int a0;
    int r0;
    int o0;
    vecs[0] = '{1'b1, 1'b1, 4,
                '{1, 2, 3, -4}, '{1, 2, 3, -4}};
    vecs[1] = '{1'b1, 1'b0, 3,
                '{10, 20, 30, 0}, '{0, 0, 0, 0}};
    vecs[2] = '{1'b0, 1'b0, 3,
                '{10, 20, 30, 0}, '{0, 0, 0, 0}};
    vecs[3] = '{1'b0, 1'b1, 3,
                '{10, 20, 30, 0}, '{30, 60, 90, 0}};
    vecs[4] = '{1'b1, 1'b1, 2,
                '{-7, 7, 0, 0}, '{-7, 7, 0, 0}};

    ifc.fold_start = 1'b0;
    ifc.first_fold = 1'b0;
    ifc.last_fold  = 1'b0;
    ifc.npix       = '0;
    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", ifc.busy, 0);
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_done", ifc.compute_done, 0);
    check("rst_out_data", ifc.out_data, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].last)
        for (int i = 0; i < vecs[v].npix; i++)
          exp_q.push_back(exp_out(vecs[v].e[i]));
      for (int i = 0; i < vecs[v].npix; i++)
        drv_q.push_back(vecs[v].d[i]);
      start_fold(vecs[v].first, vecs[v].last,
                 vecs[v].npix);
      send_beats();
      wait_done($sformatf("vec%0d", v), 40);
      check($sformatf("vec%0d_drained", v),
            exp_q.size(), 0);
    end

    // output stalls: out_ready 1,0,0,1,...
    stall_mode = 1;
    stall_k = 0;
    o0 = hs_cnt;
    begin
      int bv[5] = '{100, -200, 300, 400, -500};
      for (int i = 0; i < 5; i++) begin
        exp_q.push_back(exp_out(bv[i]));
        drv_q.push_back(bv[i]);
      end
    end
    start_fold(1'b1, 1'b1, 5);
    send_beats();
    wait_done("stall", 60);
    check("stall_hs_count", hs_cnt - o0, 5);
    check("stall_q_empty", exp_q.size(), 0);
    stall_mode = 0;

    // fold_start inside ACCUM must be ignored
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(i);
      drv_q.push_back(i);
    end
    start_fold(1'b1, 1'b1, 3);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'(drv_q.pop_front());
    @(posedge clk); #1;
    ifc.in_valid   = 1'b0;
    ifc.fold_start = 1'b1;
    ifc.first_fold = 1'b0;
    ifc.last_fold  = 1'b0;
    ifc.npix       = 16'd1;
    @(posedge clk); #1;
    ifc.fold_start = 1'b0;
    ifc.npix       = '0;
    check("ignored_start_busy", ifc.busy, 1);
    send_beats();
    wait_done("ignored_start", 40);
    check("ignored_start_q", exp_q.size(), 0);

    // npix = 0: straight to DONE, no beats, no drain
    d0 = done_cnt;
    r0 = rdy_cnt;
    o0 = ov_cnt;
    @(posedge clk); #1;
    fs = cyc;
    ifc.fold_start = 1'b1;
    ifc.first_fold = 1'b1;
    ifc.last_fold  = 1'b1;
    ifc.npix       = '0;
    @(posedge clk); #1;
    ifc.fold_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("npix0_done_count", done_cnt - d0, 1);
    check("npix0_done_window",
          (done_cyc - fs >= 1 && done_cyc - fs <= 2), 1);
    check("npix0_no_ready", rdy_cnt - r0, 0);
    check("npix0_no_outv", ov_cnt - o0, 0);

    // reset mid-fold aborts without compute_done
    d0 = done_cnt;
    drv_q.push_back(11);
    drv_q.push_back(12);
    start_fold(1'b1, 1'b1, 4);
    send_beats();
    rst = 1'b1;
    #2;
    check("abort_busy", ifc.busy, 0);
    check("abort_in_ready", ifc.in_ready, 0);
    check("abort_done", ifc.compute_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    exp_q.push_back(5);
    exp_q.push_back(6);
    drv_q.push_back(5);
    drv_q.push_back(6);
    start_fold(1'b1, 1'b1, 2);
    send_beats();
    wait_done("after_abort", 40);
    check("after_abort_q", exp_q.size(), 0);

    // npix > MAX_PIX clamps to 196 beats and outputs
    a0 = acc_cnt;
    o0 = hs_cnt;
    for (int i = 0; i < 196; i++) begin
      drv_q.push_back(i * 3 - 300);
      exp_q.push_back(exp_out(i * 3 - 300));
    end
    start_fold(1'b1, 1'b1, 300);
    send_beats();
    wait_done("clamp", 400);
    check("clamp_accepts", acc_cnt - a0, 196);
    check("clamp_outputs", hs_cnt - o0, 196);
    check("clamp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule
